// File: rtl/conv_enc_213_if.sv
// Frame/symbol handshake bundle between a bit source and the (2,1,3) convolutional encoder.
// The master drives framing and data; the slave (encoder) returns code symbols and status.
interface conv_enc_213_if #(
   parameter int N = 2,
   parameter int K = 1
);
   logic         start;
   logic [K-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic [N-1:0] Tx;
   logic         tx_valid;
   logic         seq_ready;
   logic         busy;

   modport master (
      output start, din, din_valid,
      input  din_ready, Tx, tx_valid, seq_ready, busy
   );

   modport slave (
      input  start, din, din_valid,
      output din_ready, Tx, tx_valid, seq_ready, busy
   );
endinterface

// File: rtl/conv_enc_213.sv
// Rate-1/2 memory-3 convolutional encoder: L data bits per frame, then M zero tail bits
// to drive the trellis back to state 0, then a one-cycle seq_ready pulse.
module conv_enc_213 #(
   parameter int           N  = 2,
   parameter int           K  = 1,
   parameter int           M  = 3,
   parameter int           L  = 16,
   parameter logic [M:0]   G0 = 4'b1111,
   parameter logic [M:0]   G1 = 4'b1101
) (
   input  logic          clock,
   input  logic          reset,
   conv_enc_213_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL, S_DONE} state_t;

   localparam logic [7:0] L_LAST = 8'(L - 1);
   localparam logic [7:0] M_LAST = 8'(M - 1);

   state_t         r_state;
   logic [M-1:0]   r_sr;
   logic [7:0]     r_cnt;
   logic [N-1:0]   r_tx;
   logic           r_tx_valid;
   logic           r_seq_ready;

   logic           w_u;
   logic           w_step;
   logic [M:0]     w_v;
   logic           w_c0;
   logic           w_c1;

   // Tail steps feed u=0 without waiting for the source.
   assign w_u    = (r_state == S_DATA) ? bus.din[0] : 1'b0;
   assign w_step = ((r_state == S_DATA) && bus.din_valid) || (r_state == S_TAIL);
   assign w_v    = {w_u, r_sr};
   assign w_c0   = ^(G0 & w_v);
   assign w_c1   = ^(G1 & w_v);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_tx        <= '0;
         r_tx_valid  <= 1'b0;
         r_seq_ready <= 1'b0;
      end else begin
         r_tx_valid  <= 1'b0;
         r_seq_ready <= 1'b0;
         if (w_step) begin
            r_tx       <= N'({w_c0, w_c1});
            r_tx_valid <= 1'b1;
            r_sr       <= {w_u, r_sr[M-1:1]};
         end
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_sr    <= '0;
                  r_cnt   <= '0;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (bus.din_valid) begin
                  if (r_cnt == L_LAST) begin
                     r_cnt   <= '0;
                     r_state <= S_TAIL;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            S_TAIL: begin
               if (r_cnt == M_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DONE: begin
               r_seq_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // din_ready depends on state alone so the source never sees a combinational loop.
   assign bus.din_ready = (r_state == S_DATA);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.Tx        = r_tx;
   assign bus.tx_valid  = r_tx_valid;
   assign bus.seq_ready = r_seq_ready;
endmodule

// File: tb/tb_conv_enc_213.sv
// Directed bench for conv_enc_213: an L=4 instance for symbol-level vectors and an
// L=16 instance for the long all-zero frame.
module tb_conv_enc_213;
   logic clock;
   logic reset;
   int   errors;
   int   checks;

   conv_enc_213_if #(.N(2), .K(1)) bus4 ();
   conv_enc_213_if #(.N(2), .K(1)) bus16 ();

   conv_enc_213 #(.L(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4.slave)
   );

   conv_enc_213 #(.L(16)) dut16 (
      .clock (clock),
      .reset (reset),
      .bus   (bus16.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Runs one L=4 frame on dut4 and records what came out; callers judge the results.
   task automatic run4(input logic [3:0] bits, input int stall_cycles,
                       output logic [1:0] sym [0:7], output int nsym, output int nseq,
                       output int stall_tx, output int cycles, output int first_tx);
      int   bi;
      int   st;
      logic stalled;
      nsym = 0; nseq = 0; stall_tx = 0; cycles = 0; first_tx = -1;
      bi = 0; st = 0; stalled = 1'b0;
      for (int i = 0; i < 8; i++) sym[i] = 2'b00;
      bus4.start = 1'b1;
      while (nseq == 0 && cycles < 200) begin
         @(posedge clock); #1;
         cycles++;
         bus4.start = 1'b0;
         if (bus4.tx_valid) begin
            if (nsym < 8) sym[nsym] = bus4.Tx;
            if (first_tx < 0) first_tx = cycles;
            if (stalled) stall_tx++;
            nsym++;
         end
         if (bus4.seq_ready) nseq++;
         bus4.din_valid = 1'b0;
         stalled = 1'b0;
         if (bus4.din_ready && bi < 4) begin
            if (st > 0) begin
               st--;
               stalled = 1'b1;
            end else begin
               bus4.din       = bits[bi];
               bus4.din_valid = 1'b1;
               bi++;
               st = stall_cycles;
            end
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (bus4.Tx !== 2'b00)    begin errors++; $display("FAIL reset_Tx: got %b expected 00", bus4.Tx); end
      checks++; if (bus4.tx_valid !== 1'b0)  begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", bus4.tx_valid); end
      checks++; if (bus4.seq_ready !== 1'b0) begin errors++; $display("FAIL reset_seq_ready: got %b expected 0", bus4.seq_ready); end
      checks++; if (bus4.din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b expected 0", bus4.din_ready); end
      checks++; if (bus4.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", bus4.busy); end
      reset = 1'b0;
      @(posedge clock); #1;
      $display("reset: Tx=%b tx_valid=%b busy=%b", bus4.Tx, bus4.tx_valid, bus4.busy);
   endtask

   task automatic test_impulse;
      logic [1:0] exp_sym [0:6];
      logic [1:0] sym [0:7];
      int nsym, nseq, stall_tx, cycles, first_tx;
      exp_sym = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
      run4(4'b0001, 0, sym, nsym, nseq, stall_tx, cycles, first_tx);
      checks++; if (nsym !== 7) begin errors++; $display("FAIL impulse_nsym: got %0d expected 7", nsym); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (sym[i] !== exp_sym[i]) begin errors++; $display("FAIL impulse_sym%0d: got %b expected %b", i, sym[i], exp_sym[i]); end
      end
      checks++; if (nseq !== 1)     begin errors++; $display("FAIL impulse_seq_ready: got %0d expected 1", nseq); end
      checks++; if (cycles !== 9)   begin errors++; $display("FAIL impulse_frame_cycles: got %0d expected 9", cycles); end
      checks++; if (first_tx !== 2) begin errors++; $display("FAIL impulse_latency: got %0d expected 2", first_tx); end
      checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL impulse_busy_after: got %b expected 0", bus4.busy); end
      $display("impulse: nsym=%0d seq=%0d cycles=%0d first_tx=%0d", nsym, nseq, cycles, first_tx);
   endtask

   task automatic test_all_ones;
      logic [1:0] exp_sym [0:6];
      logic [1:0] sym [0:7];
      int nsym, nseq, stall_tx, cycles, first_tx;
      exp_sym = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
      run4(4'b1111, 0, sym, nsym, nseq, stall_tx, cycles, first_tx);
      checks++; if (nsym !== 7) begin errors++; $display("FAIL ones_nsym: got %0d expected 7", nsym); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (sym[i] !== exp_sym[i]) begin errors++; $display("FAIL ones_sym%0d: got %b expected %b", i, sym[i], exp_sym[i]); end
      end
      checks++; if (dut4.r_sr !== 3'b000) begin errors++; $display("FAIL ones_final_sr: got %b expected 000", dut4.r_sr); end
      checks++; if (nseq !== 1) begin errors++; $display("FAIL ones_seq_ready: got %0d expected 1", nseq); end
      $display("all_ones: nsym=%0d seq=%0d", nsym, nseq);
   endtask

   task automatic test_all_zeros;
      int nt, ns, bad;
      nt = 0; ns = 0; bad = 0;
      bus16.start = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clock); #1;
         bus16.start = 1'b0;
         if (bus16.tx_valid) begin
            nt++;
            if (bus16.Tx !== 2'b00) bad++;
         end
         if (bus16.seq_ready) ns++;
         bus16.din       = 1'b0;
         bus16.din_valid = bus16.din_ready;
      end
      bus16.din_valid = 1'b0;
      checks++; if (nt !== 19)  begin errors++; $display("FAIL zeros_tx_count: got %0d expected 19", nt); end
      checks++; if (ns !== 1)   begin errors++; $display("FAIL zeros_seq_ready: got %0d expected 1", ns); end
      checks++; if (bad !== 0)  begin errors++; $display("FAIL zeros_nonzero_sym: got %0d expected 0", bad); end
      checks++; if (bus16.busy !== 1'b0) begin errors++; $display("FAIL zeros_busy_after: got %b expected 0", bus16.busy); end
      $display("all_zeros: tx=%0d seq=%0d nonzero=%0d", nt, ns, bad);
   endtask

   task automatic test_stall;
      logic [1:0] exp_sym [0:6];
      logic [1:0] sym [0:7];
      int nsym, nseq, stall_tx, cycles, first_tx;
      exp_sym = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
      run4(4'b0001, 3, sym, nsym, nseq, stall_tx, cycles, first_tx);
      checks++; if (nsym !== 7) begin errors++; $display("FAIL stall_nsym: got %0d expected 7", nsym); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (sym[i] !== exp_sym[i]) begin errors++; $display("FAIL stall_sym%0d: got %b expected %b", i, sym[i], exp_sym[i]); end
      end
      checks++; if (stall_tx !== 0) begin errors++; $display("FAIL stall_tx_valid: got %0d expected 0", stall_tx); end
      checks++; if (cycles !== 18)  begin errors++; $display("FAIL stall_frame_cycles: got %0d expected 18", cycles); end
      $display("stall: nsym=%0d stall_tx=%0d cycles=%0d", nsym, stall_tx, cycles);
   endtask

   task automatic test_start_ignored_and_reset;
      logic [1:0] exp_sym [0:6];
      logic [1:0] sym [0:7];
      int nsym, nseq, stall_tx, cycles, first_tx, seen;
      exp_sym = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
      bus4.start = 1'b1;
      @(posedge clock); #1;
      bus4.start = 1'b0;
      checks++; if (bus4.din_ready !== 1'b1) begin errors++; $display("FAIL midframe_din_ready: got %b expected 1", bus4.din_ready); end
      bus4.din = 1'b1; bus4.din_valid = 1'b1;
      @(posedge clock); #1;
      checks++; if (bus4.Tx !== 2'b11) begin errors++; $display("FAIL midframe_sym0: got %b expected 11", bus4.Tx); end
      // Second bit accepted together with a stray start: sr must keep the first 1.
      bus4.start = 1'b1;
      @(posedge clock); #1;
      bus4.start = 1'b0; bus4.din_valid = 1'b0;
      checks++; if (bus4.Tx !== 2'b00) begin errors++; $display("FAIL midframe_start_ignored: got %b expected 00", bus4.Tx); end
      checks++; if (bus4.tx_valid !== 1'b1) begin errors++; $display("FAIL midframe_tx_valid: got %b expected 1", bus4.tx_valid); end
      reset = 1'b1;
      #1;
      checks++; if (bus4.tx_valid !== 1'b0) begin errors++; $display("FAIL async_reset_tx_valid: got %b expected 0", bus4.tx_valid); end
      checks++; if (bus4.Tx !== 2'b00)      begin errors++; $display("FAIL async_reset_Tx: got %b expected 00", bus4.Tx); end
      checks++; if (bus4.busy !== 1'b0)     begin errors++; $display("FAIL async_reset_busy: got %b expected 0", bus4.busy); end
      checks++; if (bus4.din_ready !== 1'b0) begin errors++; $display("FAIL async_reset_din_ready: got %b expected 0", bus4.din_ready); end
      @(posedge clock); #1;
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clock); #1;
         if (bus4.seq_ready) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL aborted_seq_ready: got %0d expected 0", seen); end
      run4(4'b0001, 0, sym, nsym, nseq, stall_tx, cycles, first_tx);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (sym[i] !== exp_sym[i]) begin errors++; $display("FAIL after_reset_sym%0d: got %b expected %b", i, sym[i], exp_sym[i]); end
      end
      $display("start_ignored_and_reset: aborted_seq=%0d new_nsym=%0d", seen, nsym);
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_sym [0:6];
      logic [1:0] sym [0:7];
      int nsym, nseq, stall_tx, cycles, first_tx;
      exp_sym = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
      run4(4'b0001, 0, sym, nsym, nseq, stall_tx, cycles, first_tx);
      @(posedge clock); #1;
      checks++; if (bus4.seq_ready !== 1'b0) begin errors++; $display("FAIL b2b_seq_ready_width: got %b expected 0", bus4.seq_ready); end
      run4(4'b1111, 0, sym, nsym, nseq, stall_tx, cycles, first_tx);
      checks++; if (first_tx !== 2) begin errors++; $display("FAIL b2b_first_symbol: got %0d expected 2", first_tx); end
      checks++; if (cycles !== 9)   begin errors++; $display("FAIL b2b_frame_cycles: got %0d expected 9", cycles); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (sym[i] !== exp_sym[i]) begin errors++; $display("FAIL b2b_sym%0d: got %b expected %b", i, sym[i], exp_sym[i]); end
      end
      $display("back_to_back: first_tx=%0d cycles=%0d", first_tx, cycles);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      bus4.start = 1'b0;  bus4.din = 1'b0;  bus4.din_valid = 1'b0;
      bus16.start = 1'b0; bus16.din = 1'b0; bus16.din_valid = 1'b0;
      test_reset();
      test_impulse();
      test_all_ones();
      test_all_zeros();
      test_stall();
      test_start_ignored_and_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/conv_enc_213.md
# conv_enc_213

Rate-1/2, memory-3 (2,1,3) convolutional encoder with frame framing and trellis termination. It is the transmit-side counterpart of the (2,1,3) Viterbi decoder. It accepts a frame of `L` information bits over a valid/ready handshake and emits one 2-bit code symbol per accepted bit. It then appends `M` zero tail bits so every frame ends in state 0, and pulses `seq_ready` so the downstream decoder can start the next sequence.

## Interface
- `N`, default 2: code symbol width (bits per symbol).
- `K`, default 1: information bits per symbol.
- `M`, default 3: encoder memory (8 trellis states).
- `L`, default 16: information bits per frame, 1..255.
- `G0`, default 4'b1111: generator for `Tx[1]`; MSB taps the current input bit.
- `G1`, default 4'b1101: generator for `Tx[0]`; MSB taps the current input bit.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: begin a frame; honoured only in IDLE.
- `din` input `K`: information bit.
- `din_valid` input 1: `din` is valid this cycle.
- `din_ready` output 1: encoder accepts `din` this cycle.
- `Tx` output `N`: registered code symbol, `{c0,c1}`.
- `tx_valid` output 1: `Tx` holds a new symbol this cycle.
- `seq_ready` output 1: one-cycle pulse; the frame, including its tail, is complete.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Shift register `sr[M-1:0]` holds past inputs; `sr[M-1]` is the most recent.
- Encode vector: `v = {u, sr[M-1:0]}`.
  - `c0 = ^(G0 & v)`
  - `c1 = ^(G1 & v)`
  - After each step: `sr <= {u, sr[M-1:1]}`.
- Counter `cnt` is 8 bits wide; it counts data bits, then tail bits.

FSM states and transitions:
- IDLE: `din_ready=0`, `busy=0`.
  - `start=1`: clear `sr` to 0, set `cnt=0`, go to DATA.
- DATA: `din_ready=1`.
  - On `din_valid & din_ready`: encode with `u=din` and increment `cnt`.
  - When `cnt` reaches `L-1` on an accept: clear `cnt`, go to TAIL.
  - `din_valid=0`: stall; no symbol, `sr` held.
- TAIL: `din_ready=0`.
  - Encode with `u=0` every cycle, without waiting for any input.
  - After the `M`-th tail step, go to DONE.
- DONE: assert `seq_ready` for exactly 1 cycle, then go to IDLE.

Boundary rules:
- `start` in any state other than IDLE is ignored; the frame in progress is unaffected.
- `start` and `din_valid` high in the same cycle in IDLE: `din` is not consumed.
- After the `M` tail steps, `sr` equals 0.
- `reset` at any time, including mid-frame, returns the block to IDLE immediately. No `seq_ready` pulse is produced for the aborted frame.

## Timing
- Reset values:
  - `Tx=2'b00`, `tx_valid=0`, `seq_ready=0`, `din_ready=0`, `busy=0`.
  - State IDLE, `sr=0`, `cnt=0`.
- Latency: a bit accepted on edge t produces `Tx`/`tx_valid` during the cycle after edge t (1-cycle latency).
- `tx_valid` is high for exactly one cycle per encode step. `Tx` holds its last value while `tx_valid=0`.
- With no stalls, a frame occupies `1 + L + M + 1` cycles from `start` to `seq_ready`:
  - cycles with `din_ready` high: `L`;
  - tail cycles: `M`;
  - `seq_ready` is high in the cycle after the last tail symbol's `tx_valid` cycle.
- Minimum gap between frames: `start` may be high in the cycle after `seq_ready`.
- `din_ready` is combinational from state only. It does not depend on `din_valid`.

## Test plan
- Impulse, L=4, input 1,0,0,0, no stalls -> `Tx` = 11, 11, 10, 11, 00, 00, 00; `seq_ready` pulses one cycle after the last 00.
- All ones, L=4 -> `Tx` = 11, 00, 10, 01, 10, 01, 11; final `sr`=000.
- All zeros, L=16 -> 19 symbols, all 00; exactly 19 `tx_valid` cycles and 1 `seq_ready` pulse.
- Stalls: impulse frame with `din_valid` low for 3 cycles between bits -> same symbol sequence; no `tx_valid` during the stall cycles.
- `start` pulsed mid-DATA -> ignored, output unchanged. Then assert `reset` after 2 data bits -> all outputs go to reset values immediately and no `seq_ready` pulse. A new frame after reset encodes from `sr`=0.
- Back-to-back: `start` in the cycle after `seq_ready` -> the next frame's first symbol follows with no extra idle cycles beyond IDLE→DATA.
